// File: rtl/uab_mem_arbiter.sv
// -----------------------------------------------------------------------------
// uab_mem_arbiter
//
// Two-master, one-slave Avalon-MM style arbiter in front of the shared SDRAM
// bridge. m0 is the instruction-fetch master, m1 the data master. At most one
// transaction is outstanding: a command is presented to the slave from CMD,
// reads then park in RDWAIT until the slave returns data, which is forwarded
// to the owning master one cycle later as a single-cycle readdatavalid pulse.
// Ties in IDLE are broken round-robin against the last master whose command
// the slave accepted.
//
// Optional feature (compile-time macro UAB_ARB_TIMEOUT_EN):
//   a watchdog counts RDWAIT cycles; after TIMEOUT cycles without
//   s_readdatavalid the owning master is released with readdata 0xDEADBEEF
//   (low DATA_W bits) and the sticky arb_timeout flag is set until reset.
//   Without the macro RDWAIT waits forever and arb_timeout is tied to 0.
//
// Parameters:
//   ADDR_W   address width (word address)
//   DATA_W   data width; byteenable width is DATA_W/8
//   TIMEOUT  read watchdog limit in cycles, 1..65535 (used only with the macro)
//
// Ports:
//   clk, reset_n                 clock (rising edge), async active-low reset
//   m0_* / m1_*                  master command in, waitrequest/readdata out
//   s_address .. s_byteenable    command out to the shared slave
//   s_waitrequest, s_readdata,
//   s_readdatavalid              response in from the shared slave
//   arb_timeout                  sticky read-timeout error flag
// -----------------------------------------------------------------------------
module uab_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic [ADDR_W-1:0]   s_address,
    output logic                s_read,
    output logic                s_write,
    output logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W/8-1:0] s_byteenable,
    input  logic                s_waitrequest,
    input  logic [DATA_W-1:0]   s_readdata,
    input  logic                s_readdatavalid,

    output logic                arb_timeout
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CMD    = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    state_t state, state_nxt;

    // grant/last encode the master: 0 = m0, 1 = m1
    logic grant, grant_nxt;
    logic last, last_nxt;

    logic req0, req1;

    logic              g_read;
    logic              g_write;
    logic [ADDR_W-1:0] g_address;
    logic [DATA_W-1:0] g_writedata;
    logic [BE_W-1:0]   g_byteenable;

    logic              rsp_fire;
    logic [DATA_W-1:0] rsp_data;

    logic              vld0_p1;
    logic              vld1_p1;
    logic [DATA_W-1:0] rdata_p1;

`ifdef UAB_ARB_TIMEOUT_EN
    localparam logic [15:0]       TO_LAST = 16'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] TO_DATA = DATA_W'(32'hDEADBEEF);

    logic [15:0] to_cnt;
    logic        to_fire;
    logic        timeout_flag;
`else
    logic [31:0] timeout_unused;
    assign timeout_unused = 32'(TIMEOUT);
`endif

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Mux of the currently granted master's command
    assign g_read       = grant ? m1_read       : m0_read;
    assign g_write      = grant ? m1_write      : m0_write;
    assign g_address    = grant ? m1_address    : m0_address;
    assign g_writedata  = grant ? m1_writedata  : m0_writedata;
    assign g_byteenable = grant ? m1_byteenable : m0_byteenable;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        last_nxt  = last;
        rsp_fire  = 1'b0;
        rsp_data  = s_readdata;
`ifdef UAB_ARB_TIMEOUT_EN
        to_fire   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_nxt = CMD;
                    if (req0 && req1) begin
                        grant_nxt = ~last;
                    end else begin
                        grant_nxt = req1;
                    end
                end
            end

            CMD: begin
                if (!(g_read || g_write)) begin
                    // master withdrew before acceptance: no fairness credit
                    state_nxt = IDLE;
                end else if (!s_waitrequest) begin
                    last_nxt  = grant;
                    state_nxt = g_read ? RDWAIT : IDLE;
                end
            end

            RDWAIT: begin
                if (s_readdatavalid) begin
                    rsp_fire  = 1'b1;
                    state_nxt = IDLE;
                end
`ifdef UAB_ARB_TIMEOUT_EN
                else if (to_cnt == TO_LAST) begin
                    rsp_fire  = 1'b1;
                    rsp_data  = TO_DATA;
                    to_fire   = 1'b1;
                    state_nxt = IDLE;
                end
`endif
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Slave command and master stall (combinational from state/grant)
    // -------------------------------------------------------------------------
    always_comb begin
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_address      = '0;
        s_writedata    = '0;
        s_byteenable   = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        if (state == CMD) begin
            s_read       = g_read;
            // read has priority if a master raises both strobes
            s_write      = g_write & ~g_read;
            s_address    = g_address;
            s_writedata  = g_writedata;
            s_byteenable = g_byteenable;
            if (grant) begin
                m1_waitrequest = s_waitrequest;
            end else begin
                m0_waitrequest = s_waitrequest;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            grant   <= 1'b0;
            last    <= 1'b1;
            vld0_p1 <= 1'b0;
            vld1_p1 <= 1'b0;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            last    <= last_nxt;
            vld0_p1 <= rsp_fire & ~grant;
            vld1_p1 <= rsp_fire &  grant;
        end
    end

    // -------------------------------------------------------------------------
    // Stage p1: registered read return
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rsp_fire) begin
            rdata_p1 <= rsp_data;
        end
    end

    // Data register is unreset; gating by valid keeps idle readdata at zero
    assign m0_readdatavalid = vld0_p1;
    assign m1_readdatavalid = vld1_p1;
    assign m0_readdata      = vld0_p1 ? rdata_p1 : '0;
    assign m1_readdata      = vld1_p1 ? rdata_p1 : '0;

`ifdef UAB_ARB_TIMEOUT_EN
    // -------------------------------------------------------------------------
    // Read watchdog: counts cycles spent in RDWAIT, cleared elsewhere
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt       <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (state == RDWAIT) begin
                to_cnt <= to_cnt + 16'd1;
            end else begin
                to_cnt <= '0;
            end
            if (to_fire) begin
                timeout_flag <= 1'b1;
            end
        end
    end

    assign arb_timeout = timeout_flag;
`else
    assign arb_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uab_mem_arbiter.sv
`timescale 1ns/1ps
module tb_uab_mem_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int BOUND = 100;
`ifdef UAB_ARB_TIMEOUT_EN
    localparam int RW = 5;
`else
    localparam int RW = 20;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;

    logic [AW-1:0] m0_address = '0;
    logic          m0_read = 1'b0;
    logic          m0_write = 1'b0;
    logic [DW-1:0] m0_writedata = '0;
    logic [3:0]    m0_byteenable = '0;
    logic          m0_waitrequest;
    logic [DW-1:0] m0_readdata;
    logic          m0_readdatavalid;

    logic [AW-1:0] m1_address = '0;
    logic          m1_read = 1'b0;
    logic          m1_write = 1'b0;
    logic [DW-1:0] m1_writedata = '0;
    logic [3:0]    m1_byteenable = '0;
    logic          m1_waitrequest;
    logic [DW-1:0] m1_readdata;
    logic          m1_readdatavalid;

    logic [AW-1:0] s_address;
    logic          s_read;
    logic          s_write;
    logic [DW-1:0] s_writedata;
    logic [3:0]    s_byteenable;
    logic          s_waitrequest = 1'b0;
    logic [DW-1:0] s_readdata = '0;
    logic          s_readdatavalid = 1'b0;
    logic          arb_timeout;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } cmd_t;

    typedef struct packed {
        logic        m;
        logic [31:0] data;
    } rsp_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];

    int total = 0;
    int bad   = 0;

    uab_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid),
        .arb_timeout(arb_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s: wait bound of %0d cycles expired, required event never seen", nm, BOUND);
    endtask

    function automatic logic wreq(input bit m);
        return m ? m1_waitrequest : m0_waitrequest;
    endfunction

    function automatic logic rvld(input bit m);
        return m ? m1_readdatavalid : m0_readdatavalid;
    endfunction

    task automatic drive_m(input bit m, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        if (!m) begin
            m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
        end else begin
            m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
        end
    endtask

    // Avalon-style master: hold the request until waitrequest is low at an edge
    task automatic m_xfer(input bit m, input bit rd, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be, input bit wait_rsp);
        int w;
        drive_m(m, rd, !rd, a, d, be);
        w = 0;
        while (w < BOUND) begin
            @(negedge clk);
            if (!wreq(m)) break;
            w++;
        end
        if (w == BOUND) bound_fail("master_accept");
        @(posedge clk);
        #1 drive_m(m, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        if (wait_rsp) begin
            w = 0;
            while (w < BOUND) begin
                @(negedge clk);
                if (rvld(m)) break;
                w++;
            end
            if (w == BOUND) bound_fail("master_rsp");
        end
    endtask

    // Slave: answers n reads, valid asserted in the lat-th RDWAIT cycle
    task automatic slave_reads(input int n, input int lat, input bit derive, input logic [31:0] fixed);
        for (int i = 0; i < n; i++) begin
            logic [31:0] a;
            int w;
            w = 0;
            while (w < BOUND) begin
                @(negedge clk);
                if (s_read && !s_waitrequest) break;
                w++;
            end
            if (w == BOUND) begin
                bound_fail("slave_accept");
                return;
            end
            a = s_address;
            @(posedge clk);
            repeat (lat - 1) @(posedge clk);
            #1;
            s_readdatavalid = 1'b1;
            s_readdata = derive ? {16'hD000, a[15:0]} : fixed;
            @(posedge clk);
            #1;
            s_readdatavalid = 1'b0;
            s_readdata = '0;
            @(negedge clk);
            chk1("rsp_latency", m0_readdatavalid | m1_readdatavalid, 1'b1);
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic late_valid();
        s_readdatavalid = 1'b1;
        s_readdata = 32'h0000_0099;
        @(posedge clk);
        #1;
        s_readdatavalid = 1'b0;
        s_readdata = '0;
        repeat (3) begin
            @(negedge clk);
            chk1("late_m0_vld", m0_readdatavalid, 1'b0);
            chk1("late_m1_vld", m1_readdatavalid, 1'b0);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a transfer
    always @(negedge clk) begin
        if (reset_n) begin
            if ((s_read || s_write) && !s_waitrequest) begin
                if (cmd_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL cmd_unexpected: got addr %h rd %b wr %b, expected no command",
                             s_address, s_read, s_write);
                end else begin
                    cmd_t e;
                    e = cmd_q.pop_front();
                    chk1("cmd_rd", s_read, e.rd);
                    chk1("cmd_wr", s_write, e.wr);
                    chk32("cmd_addr", s_address, e.addr);
                    if (e.wr) begin
                        chk32("cmd_wdata", s_writedata, e.wdata);
                        chk32("cmd_be", {28'd0, s_byteenable}, {28'd0, e.be});
                    end
                end
            end
            if (m0_readdatavalid || m1_readdatavalid) begin
                if (rsp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rsp_unexpected: got vld m0=%b m1=%b, expected none",
                             m0_readdatavalid, m1_readdatavalid);
                end else begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    chk1("rsp_m0_vld", m0_readdatavalid, !r.m);
                    chk1("rsp_m1_vld", m1_readdatavalid, r.m);
                    chk32("rsp_data", r.m ? m1_readdata : m0_readdata, r.data);
                end
            end
            if (!m0_readdatavalid) chk32("m0_rdata_idle", m0_readdata, 32'h0);
            if (!m1_readdatavalid) chk32("m1_rdata_idle", m1_readdata, 32'h0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "tb_uab_mem_arbiter time limit");
    end

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk1("rst_m0_wait", m0_waitrequest, 1'b1);
        chk1("rst_m1_wait", m1_waitrequest, 1'b1);
        chk1("rst_s_read", s_read, 1'b0);
        chk1("rst_s_write", s_write, 1'b0);
        chk32("rst_s_addr", s_address, 32'h0);
        chk32("rst_s_wdata", s_writedata, 32'h0);
        chk32("rst_s_be", {28'd0, s_byteenable}, 32'h0);
        chk1("rst_m0_vld", m0_readdatavalid, 1'b0);
        chk1("rst_m1_vld", m1_readdatavalid, 1'b0);
        chk1("rst_timeout", arb_timeout, 1'b0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // single m0 read, response three cycles after acceptance
        cmd_q.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h100, wdata: 32'h0, be: 4'hF});
        rsp_q.push_back('{m: 1'b0, data: 32'h1234_5678});
        fork
            m_xfer(1'b0, 1'b1, 32'h100, 32'h0, 4'hF, 1'b1);
            slave_reads(1, 3, 1'b0, 32'h1234_5678);
            repeat (8) begin
                @(negedge clk);
                chk1("m1_untouched_wait", m1_waitrequest, 1'b1);
            end
        join

        // simultaneous writes after reset: m0 wins the first tie
        pulse_reset();
        cmd_q.push_back('{rd: 1'b0, wr: 1'b1, addr: 32'hA, wdata: 32'hAAAA_0001, be: 4'hF});
        cmd_q.push_back('{rd: 1'b0, wr: 1'b1, addr: 32'hB, wdata: 32'hBBBB_0002, be: 4'hF});
        fork
            m_xfer(1'b0, 1'b0, 32'hA, 32'hAAAA_0001, 4'hF, 1'b0);
            m_xfer(1'b1, 1'b0, 32'hB, 32'hBBBB_0002, 4'hF, 1'b0);
            begin
                @(negedge clk);
                chk1("tie_idle_m0_wait", m0_waitrequest, 1'b1);
                chk1("tie_idle_m1_wait", m1_waitrequest, 1'b1);
                @(negedge clk);
                chk1("tie_m0_grant_wait", m0_waitrequest, 1'b0);
                chk1("tie_m1_held_wait", m1_waitrequest, 1'b1);
                chk32("tie_first_addr", s_address, 32'hA);
            end
        join

        // continuous reads from both masters alternate m0, m1, m0, m1
        cmd_q.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h200, wdata: 32'h0, be: 4'hF});
        cmd_q.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h300, wdata: 32'h0, be: 4'hF});
        cmd_q.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h204, wdata: 32'h0, be: 4'hF});
        cmd_q.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h304, wdata: 32'h0, be: 4'hF});
        rsp_q.push_back('{m: 1'b0, data: 32'hD000_0200});
        rsp_q.push_back('{m: 1'b1, data: 32'hD000_0300});
        rsp_q.push_back('{m: 1'b0, data: 32'hD000_0204});
        rsp_q.push_back('{m: 1'b1, data: 32'hD000_0304});
        fork
            begin
                m_xfer(1'b0, 1'b1, 32'h200, 32'h0, 4'hF, 1'b1);
                m_xfer(1'b0, 1'b1, 32'h204, 32'h0, 4'hF, 1'b1);
            end
            begin
                m_xfer(1'b1, 1'b1, 32'h300, 32'h0, 4'hF, 1'b1);
                m_xfer(1'b1, 1'b1, 32'h304, 32'h0, 4'hF, 1'b1);
            end
            slave_reads(4, 1, 1'b1, 32'h0);
        join

        // m1 write stalled by the slave for five cycles
        s_waitrequest = 1'b1;
        cmd_q.push_back('{rd: 1'b0, wr: 1'b1, addr: 32'hC0, wdata: 32'hCAFE_F00D, be: 4'h3});
        fork
            m_xfer(1'b1, 1'b0, 32'hC0, 32'hCAFE_F00D, 4'h3, 1'b0);
            begin
                @(negedge clk);
                repeat (5) begin
                    @(negedge clk);
                    chk1("stall_m1_wait", m1_waitrequest, 1'b1);
                    chk1("stall_m0_wait", m0_waitrequest, 1'b1);
                    chk1("stall_s_write", s_write, 1'b1);
                    chk32("stall_s_wdata", s_writedata, 32'hCAFE_F00D);
                end
                @(posedge clk);
                #1 s_waitrequest = 1'b0;
            end
        join

        // m0 withdraws in CMD; fairness state must not move
        s_waitrequest = 1'b1;
        drive_m(1'b0, 1'b0, 1'b1, 32'hD0, 32'h1, 4'hF);
        @(negedge clk);
        @(negedge clk);
        chk1("drop_cmd_write", s_write, 1'b1);
        chk32("drop_cmd_addr", s_address, 32'hD0);
        @(posedge clk);
        #1 drive_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        @(posedge clk);
        #1 s_waitrequest = 1'b0;
        cmd_q.push_back('{rd: 1'b0, wr: 1'b1, addr: 32'hE0, wdata: 32'h0000_00E0, be: 4'hF});
        cmd_q.push_back('{rd: 1'b0, wr: 1'b1, addr: 32'hE1, wdata: 32'h0000_00E1, be: 4'hF});
        fork
            m_xfer(1'b0, 1'b0, 32'hE0, 32'h0000_00E0, 4'hF, 1'b0);
            m_xfer(1'b1, 1'b0, 32'hE1, 32'h0000_00E1, 4'hF, 1'b0);
        join

        // reset while a read is waiting for its response
        cmd_q.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h400, wdata: 32'h0, be: 4'hF});
        m_xfer(1'b0, 1'b1, 32'h400, 32'h0, 4'hF, 1'b0);
        repeat (RW) begin
            @(negedge clk);
            chk1("rdwait_no_vld", m0_readdatavalid, 1'b0);
        end
        #2 reset_n = 1'b0;
        #1;
        chk1("midrst_m0_wait", m0_waitrequest, 1'b1);
        chk1("midrst_m1_wait", m1_waitrequest, 1'b1);
        chk1("midrst_s_read", s_read, 1'b0);
        chk1("midrst_s_write", s_write, 1'b0);
        chk32("midrst_s_addr", s_address, 32'h0);
        chk1("midrst_m0_vld", m0_readdatavalid, 1'b0);
        chk1("midrst_m1_vld", m1_readdatavalid, 1'b0);
        chk1("midrst_timeout", arb_timeout, 1'b0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        late_valid();

`ifdef UAB_ARB_TIMEOUT_EN
        // unanswered read released by the watchdog after 16 RDWAIT cycles
        begin
            int n;
            n = 0;
            cmd_q.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h500, wdata: 32'h0, be: 4'hF});
            rsp_q.push_back('{m: 1'b1, data: 32'hDEAD_BEEF});
            m_xfer(1'b1, 1'b1, 32'h500, 32'h0, 4'hF, 1'b0);
            for (int i = 1; i <= 40; i++) begin
                @(posedge clk);
                @(negedge clk);
                if (m1_readdatavalid) begin
                    n = i;
                    break;
                end
            end
            chk32("timeout_cycles", 32'(n), 32'd16);
            chk1("timeout_flag_set", arb_timeout, 1'b1);
            @(posedge clk);
            #1;
            late_valid();
            chk1("timeout_flag_sticky", arb_timeout, 1'b1);
            pulse_reset();
            @(negedge clk);
            chk1("timeout_flag_cleared", arb_timeout, 1'b0);
        end
`else
        chk1("timeout_tied_low", arb_timeout, 1'b0);
`endif

        repeat (2) @(negedge clk);
        chk32("cmd_queue_drained", 32'(cmd_q.size()), 32'd0);
        chk32("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uab_mem_arbiter.md
UAB_MEM_ARBITER -- requirements
Module: uab_mem_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL have parameter ADDR_W, default 32, giving the address width in bits.
REQ-003 The block SHALL have parameter DATA_W, default 32, giving the data width in bits; byteenable width is DATA_W/8.
REQ-004 The block SHALL have parameter TIMEOUT, default 255, giving the read-response watchdog limit in cycles, legal range 1..65535.
REQ-005 The block SHALL have port clk, input, 1 bit: system clock; all logic is rising-edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have ports m0_address and m1_address, input, ADDR_W bits: master word address (m0 = instruction fetch, m1 = data).
REQ-008 The block SHALL have ports m0_read/m0_write and m1_read/m1_write, input, 1 bit each: master read and write requests.
REQ-009 The block SHALL have ports m0_writedata and m1_writedata, input, DATA_W bits, and m0_byteenable and m1_byteenable, input, DATA_W/8 bits.
REQ-010 The block SHALL have ports m0_waitrequest and m1_waitrequest, output, 1 bit: stall to each master.
REQ-011 The block SHALL have ports m0_readdata and m1_readdata, output, DATA_W bits, and m0_readdatavalid and m1_readdatavalid, output, 1 bit: read return to each master.
REQ-012 The block SHALL have ports s_address (ADDR_W), s_read, s_write, s_writedata (DATA_W) and s_byteenable (DATA_W/8), all outputs: command to the shared SDRAM bridge slave.
REQ-013 The block SHALL have ports s_waitrequest (1), s_readdata (DATA_W) and s_readdatavalid (1), all inputs: response from the shared slave.
REQ-014 The block SHALL have port arb_timeout, output, 1 bit: sticky read-timeout error flag.

Function
REQ-015 The FSM SHALL have three states: IDLE, CMD and RDWAIT; it keeps one transaction outstanding at most.
REQ-016 In IDLE, any mX_read or mX_write SHALL cause a grant and a move to CMD on the next edge; with both masters requesting, the master not granted last wins (round-robin).
REQ-017 In CMD, the s_* command outputs SHALL be driven combinationally from the granted master; when both read and write are asserted, only s_read is driven.
REQ-018 In IDLE and RDWAIT, s_read, s_write, s_address, s_writedata and s_byteenable SHALL all be 0.
REQ-019 The granted master's mX_waitrequest SHALL equal s_waitrequest while in CMD; otherwise every mX_waitrequest SHALL be 1.
REQ-020 When a write is accepted in CMD (s_waitrequest=0), the FSM SHALL go to IDLE and update the last-granted master.
REQ-021 When a read is accepted in CMD, the FSM SHALL go to RDWAIT and update the last-granted master.
REQ-022 If the granted master drops its request in CMD before acceptance, the FSM SHALL return to IDLE without updating last-granted.
REQ-023 In RDWAIT, s_readdatavalid=1 SHALL produce a one-cycle mX_readdatavalid pulse and mX_readdata=s_readdata, registered (one-cycle latency), to the granted master only, then the FSM goes to IDLE.
REQ-024 s_readdatavalid outside RDWAIT SHALL be discarded.
REQ-025 When no valid pulse is being returned, mX_readdata SHALL be 0 and mX_readdatavalid SHALL be 0.
REQ-026 Minimum latency SHALL be one cycle from request to command on the slave, and one cycle from s_readdatavalid to mX_readdatavalid.

Reset
REQ-027 reset_n=0 at any time, including mid-CMD or mid-RDWAIT, SHALL immediately force IDLE, set last-granted=m1 (so m0 wins the first tie), clear arb_timeout and the watchdog counter, drive all outputs to 0 except mX_waitrequest=1, and drop any in-flight read without a response.

Configuration
REQ-028 With macro UAB_ARB_TIMEOUT_EN defined, a counter SHALL run in RDWAIT; after TIMEOUT cycles without s_readdatavalid, the granted master receives a valid pulse with readdata=32'hDEADBEEF (lower DATA_W bits), arb_timeout is set until reset, and the FSM goes to IDLE.
REQ-029 Without UAB_ARB_TIMEOUT_EN, RDWAIT SHALL wait indefinitely, arb_timeout SHALL be tied to 0, and TIMEOUT SHALL be unused.

Verification
REQ-030 m0 read 0x100, s_waitrequest=0, s_readdatavalid 3 cycles later with 0x12345678 -> m0_readdatavalid one-cycle pulse carrying 0x12345678; m1 outputs unchanged.
REQ-031 After reset, m0 and m1 assert writes in the same cycle (0xA, 0xB) -> slave sees 0xA first, then 0xB; m1_waitrequest stays 1 until its grant.
REQ-032 m0 and m1 issue back-to-back reads continuously -> slave grant order is m0, m1, m0, m1.
REQ-033 m1 write with s_waitrequest held 5 cycles -> m1_waitrequest=1 for 5 cycles, s_write and s_writedata stable, then accepted.
REQ-034 UAB_ARB_TIMEOUT_EN defined, TIMEOUT=16, read with no response -> after 16 RDWAIT cycles, readdata=0xDEADBEEF with a valid pulse, arb_timeout=1; a late s_readdatavalid is discarded.
REQ-035 reset_n pulsed low during RDWAIT -> FSM in IDLE, no readdatavalid pulse, all mX_waitrequest=1, s_* outputs=0.
